// File: rtl/up.sv
// Minimal single-cycle 8-bit processor: PC, four registers, ALU with Z/C flags,
// decoder and a fixed internal program ROM. It runs autonomously from reset.
module up (
  input logic Clock,
  input logic Reset
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_MOV = 4'h7,
    OP_JMP = 4'h8, OP_JZ  = 4'h9, OP_JNZ = 4'hA, OP_INC = 4'hB,
    OP_DEC = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE, OP_HLT = 4'hF
  } opcode_t;

  logic [7:0]  pc;
  logic [7:0]  r0, r1, r2, r3;
  logic        zflag, cflag, halted;
  logic [15:0] instr;

  opcode_t     op;
  logic [1:0]  rd, rs;
  logic [7:0]  imm;
  logic [7:0]  a, b;
  logic [7:0]  pc_next;
  logic [7:0]  result;
  logic        c_new;
  logic        wr_en;
  logic        flag_en;
  logic        halt_next;

  // Fixed program; every unlisted address holds NOP.
  function automatic logic [15:0] rom_word(input logic [7:0] addr);
    case (addr)
      8'h00:   rom_word = 16'h1005;
      8'h01:   rom_word = 16'h1403;
      8'h02:   rom_word = 16'h2100;
      8'h03:   rom_word = 16'h3100;
      8'h04:   rom_word = 16'h1803;
      8'h05:   rom_word = 16'hC800;
      8'h06:   rom_word = 16'hA005;
      8'h07:   rom_word = 16'h7C00;
      8'h08:   rom_word = 16'hF000;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] reg_read(input logic [1:0] sel,
                                          input logic [7:0] v0, input logic [7:0] v1,
                                          input logic [7:0] v2, input logic [7:0] v3);
    case (sel)
      2'd0:    reg_read = v0;
      2'd1:    reg_read = v1;
      2'd2:    reg_read = v2;
      2'd3:    reg_read = v3;
      default: reg_read = 8'h00;
    endcase
  endfunction

  assign instr = rom_word(pc);
  assign op    = opcode_t'(instr[15:12]);
  assign rd    = instr[11:10];
  assign rs    = instr[9:8];
  assign imm   = instr[7:0];
  assign a     = reg_read(rd, r0, r1, r2, r3);
  assign b     = reg_read(rs, r0, r1, r2, r3);

  // Decode and execute the current instruction into next-state values.
  always_comb begin
    pc_next   = pc + 8'd1;
    result    = 8'h00;
    c_new     = 1'b0;
    wr_en     = 1'b0;
    flag_en   = 1'b0;
    halt_next = halted;
    if (halted) begin
      pc_next = pc;
    end else begin
      case (op)
        OP_NOP: ;
        OP_LDI: begin result = imm; wr_en = 1'b1; end
        OP_MOV: begin result = b;   wr_en = 1'b1; end
        OP_ADD: begin {c_new, result} = {1'b0, a} + {1'b0, b}; wr_en = 1'b1; flag_en = 1'b1; end
        OP_SUB: begin result = a - b; c_new = (a < b); wr_en = 1'b1; flag_en = 1'b1; end
        OP_AND: begin result = a & b; wr_en = 1'b1; flag_en = 1'b1; end
        OP_OR:  begin result = a | b; wr_en = 1'b1; flag_en = 1'b1; end
        OP_XOR: begin result = a ^ b; wr_en = 1'b1; flag_en = 1'b1; end
        OP_INC: begin {c_new, result} = {1'b0, a} + 9'd1; wr_en = 1'b1; flag_en = 1'b1; end
        OP_DEC: begin result = a - 8'd1; c_new = (a == 8'h00); wr_en = 1'b1; flag_en = 1'b1; end
        OP_SHL: begin result = {a[6:0], 1'b0}; c_new = a[7]; wr_en = 1'b1; flag_en = 1'b1; end
        OP_SHR: begin result = {1'b0, a[7:1]}; c_new = a[0]; wr_en = 1'b1; flag_en = 1'b1; end
        OP_JMP: pc_next = imm;
        OP_JZ: begin
          if (zflag) pc_next = imm;
          else       pc_next = pc + 8'd1;
        end
        OP_JNZ: begin
          if (!zflag) pc_next = imm;
          else        pc_next = pc + 8'd1;
        end
        // HLT parks the PC on its own address.
        OP_HLT: begin halt_next = 1'b1; pc_next = pc; end
        default: ;
      endcase
    end
  end

  // Commit architectural state; reset overrides everything, including halt.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc     <= 8'h00;
      r0     <= 8'h00;
      r1     <= 8'h00;
      r2     <= 8'h00;
      r3     <= 8'h00;
      zflag  <= 1'b0;
      cflag  <= 1'b0;
      halted <= 1'b0;
    end else if (!halted) begin
      pc     <= pc_next;
      halted <= halt_next;
      if (wr_en) begin
        case (rd)
          2'd0:    r0 <= result;
          2'd1:    r1 <= result;
          2'd2:    r2 <= result;
          2'd3:    r3 <= result;
          default: ;
        endcase
      end
      if (flag_en) begin
        zflag <= (result == 8'h00);
        cflag <= c_new;
      end
    end
  end

endmodule

// File: tb/tb_up.sv
// Directed bench for up: walks the built-in program edge by edge and checks
// architectural state through hierarchical references.
module tb_up;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;

  up dut (
    .Clock(Clock),
    .Reset(Reset)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_pc"}, {8'h00, dut.pc}, 16'h0000);
    chk({tag, "_r0"}, {8'h00, dut.r0}, 16'h0000);
    chk({tag, "_r1"}, {8'h00, dut.r1}, 16'h0000);
    chk({tag, "_r2"}, {8'h00, dut.r2}, 16'h0000);
    chk({tag, "_r3"}, {8'h00, dut.r3}, 16'h0000);
    chk({tag, "_flags"}, {13'h0, dut.zflag, dut.cflag, dut.halted}, 16'h0000);
    chk({tag, "_instr"}, dut.instr, 16'h1005);
  endtask

  task automatic chk_final(input string tag);
    chk({tag, "_pc"}, {8'h00, dut.pc}, 16'h0008);
    chk({tag, "_r0"}, {8'h00, dut.r0}, 16'h0005);
    chk({tag, "_r1"}, {8'h00, dut.r1}, 16'h0003);
    chk({tag, "_r2"}, {8'h00, dut.r2}, 16'h0000);
    chk({tag, "_r3"}, {8'h00, dut.r3}, 16'h0005);
    // z=1 from DEC reaching 0, c=0, halted=1
    chk({tag, "_zch"}, {13'h0, dut.zflag, dut.cflag, dut.halted}, 16'h0005);
    chk({tag, "_instr"}, dut.instr, 16'hF000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    step(1);
    chk_cleared("reset");
    Reset = 1'b0;

    step(1); chk("e1_r0", {8'h00, dut.r0}, 16'h0005);
    step(1); chk("e2_r1", {8'h00, dut.r1}, 16'h0003);
    step(1); chk("e3_r0", {8'h00, dut.r0}, 16'h0008);
    chk("e3_zc", {14'h0, dut.zflag, dut.cflag}, 16'h0000);
    step(1); chk("e4_r0", {8'h00, dut.r0}, 16'h0005);
    chk("e4_zc", {14'h0, dut.zflag, dut.cflag}, 16'h0000);
    chk("e4_pc", {8'h00, dut.pc}, 16'h0004);
    step(1); chk("e5_r2", {8'h00, dut.r2}, 16'h0003);
    step(1); chk("e6_r2", {8'h00, dut.r2}, 16'h0002);
    chk("e6_pc", {8'h00, dut.pc}, 16'h0006);
    step(1); chk("e7_jnz_taken", {8'h00, dut.pc}, 16'h0005);
    step(1); chk("e8_r2", {8'h00, dut.r2}, 16'h0001);
    step(1); chk("e9_jnz_taken", {8'h00, dut.pc}, 16'h0005);
    step(1); chk("e10_r2", {8'h00, dut.r2}, 16'h0000);
    chk("e10_zc", {14'h0, dut.zflag, dut.cflag}, 16'h0002);
    step(1); chk("e11_fall", {8'h00, dut.pc}, 16'h0007);
    step(1); chk("e12_r3", {8'h00, dut.r3}, 16'h0005);
    chk("e12_not_halted", {15'h0, dut.halted}, 16'h0000);
    step(1); chk_final("halt");

    step(10); chk_final("frozen");

    Reset = 1'b1;
    step(1); chk_cleared("rst_halted");
    Reset = 1'b0;
    step(13); chk_final("rerun1");

    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    step(6);
    chk("midloop_pc", {8'h00, dut.pc}, 16'h0006);
    chk("midloop_r2", {8'h00, dut.r2}, 16'h0002);
    Reset = 1'b1;
    step(1); chk_cleared("rst_mid");
    Reset = 1'b0;
    step(13); chk_final("rerun2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
